// File: rtl/vec_lane_sequencer_pkg.sv
// Shared opcodes, widths and sequencer state encoding for the vector lane sequencer.
// Opcode values mirror the pipeline's global opcode map.
package vec_lane_sequencer_pkg;

    localparam int OPCODE_WIDTH  = 8;
    localparam int VREG_ID_WIDTH = 6;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D     = 8'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_VADD      = 8'h20;
    localparam logic [OPCODE_WIDTH-1:0] OP_VMOV      = 8'h21;
    localparam logic [OPCODE_WIDTH-1:0] OP_VMOVI     = 8'h22;
    localparam logic [OPCODE_WIDTH-1:0] OP_VCOMPMOV  = 8'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_VCOMPMOVI = 8'h24;

    typedef enum logic [1:0] {
        VSEQ_IDLE = 2'b00,
        VSEQ_RUN  = 2'b01,
        VSEQ_DONE = 2'b10
    } vseq_state_e;

    function automatic logic is_vec_op(input logic [OPCODE_WIDTH-1:0] op);
        case (op)
            OP_VADD, OP_VMOV, OP_VMOVI, OP_VCOMPMOV, OP_VCOMPMOVI: is_vec_op = 1'b1;
            default:                                               is_vec_op = 1'b0;
        endcase
    endfunction

    // Compare-move ops touch a single lane and finish after one RUN cycle.
    function automatic logic is_comp_op(input logic [OPCODE_WIDTH-1:0] op);
        case (op)
            OP_VCOMPMOV, OP_VCOMPMOVI: is_comp_op = 1'b1;
            default:                   is_comp_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-lane ALU shared by every lane of a vector op.
module vec_lane_alu
    import vec_lane_sequencer_pkg::*;
#(
    parameter int LANE_W = 16
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [LANE_W-1:0]       a,
    input  logic [LANE_W-1:0]       b,
    input  logic [LANE_W-1:0]       imm,
    output logic [LANE_W-1:0]       result
);

    // Lane result select; carry out of VADD is intentionally dropped.
    always_comb begin
        result = {LANE_W{1'b0}};
        case (opcode)
            OP_VADD:      result = a + b;
            OP_VMOV:      result = a;
            OP_VMOVI:     result = imm;
            OP_VCOMPMOV:  result = b;
            OP_VCOMPMOVI: result = imm;
            default:      result = {LANE_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/vec_lane_sequencer.sv
// EX-stage vector op sequencer: runs one vector instruction lane by lane through a shared ALU.
// Optional macro VEC_LANE_PAIR_EN adds a second ALU so two lanes complete per cycle.
module vec_lane_sequencer
    import vec_lane_sequencer_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 16
) (
    input  logic                         I_CLOCK,
    input  logic                         I_RESET,
    input  logic                         I_Valid,
    input  logic [OPCODE_WIDTH-1:0]      I_Opcode,
    input  logic [VREG_ID_WIDTH-1:0]     I_DestVRegIdx,
    input  logic [LANES*LANE_W-1:0]      I_VecSrc1Value,
    input  logic [LANES*LANE_W-1:0]      I_VecSrc2Value,
    input  logic [LANE_W-1:0]            I_Imm,
    input  logic [$clog2(LANES)-1:0]     I_Idx,
    input  logic                         I_GPUStallSignal,
    output logic                         O_Ready,
    output logic                         O_Valid,
    output logic [VREG_ID_WIDTH-1:0]     O_DestVRegIdx,
    output logic [LANES*LANE_W-1:0]      O_VecDestValue,
    output logic                         O_VRegWEn,
    output logic                         O_Busy
);

    localparam int VEC_W     = LANES * LANE_W;
    localparam int LANE_ID_W = $clog2(LANES);
`ifdef VEC_LANE_PAIR_EN
    localparam int LANE_STEP = 2;
`else
    localparam int LANE_STEP = 1;
`endif
    localparam logic [LANE_ID_W-1:0] LAST_LANE = LANE_ID_W'(LANES - LANE_STEP);
    localparam logic [LANE_ID_W-1:0] STEP      = LANE_ID_W'(LANE_STEP);

    vseq_state_e                state_r, state_nxt_s;
    logic [LANE_ID_W-1:0]       lane_r, lane_nxt_s;
    logic [VEC_W-1:0]           result_r, result_nxt_s;
    logic [VEC_W-1:0]           s1_r, s2_r;
    logic [LANE_W-1:0]          imm_r;
    logic [LANE_ID_W-1:0]       idx_r;
    logic [OPCODE_WIDTH-1:0]    op_r;
    logic [VREG_ID_WIDTH-1:0]   dest_r;
    logic                       ready_r, valid_r, busy_r;
    logic                       accept_s, comp_s;
    logic [LANE_W-1:0]          alu_b0_s, alu_y0_s;

    assign comp_s   = is_comp_op(op_r);
    // Compare-move takes its lane value from source 2 lane 0 regardless of target lane.
    assign alu_b0_s = comp_s ? s2_r[LANE_W-1:0] : s2_r[lane_r*LANE_W +: LANE_W];

    vec_lane_alu #(.LANE_W(LANE_W)) u_alu0 (
        .opcode (op_r),
        .a      (s1_r[lane_r*LANE_W +: LANE_W]),
        .b      (alu_b0_s),
        .imm    (imm_r),
        .result (alu_y0_s)
    );

`ifdef VEC_LANE_PAIR_EN
    logic [LANE_ID_W-1:0] lane_hi_s;
    logic [LANE_W-1:0]    alu_y1_s;

    assign lane_hi_s = lane_r + LANE_ID_W'(1);

    vec_lane_alu #(.LANE_W(LANE_W)) u_alu1 (
        .opcode (op_r),
        .a      (s1_r[lane_hi_s*LANE_W +: LANE_W]),
        .b      (s2_r[lane_hi_s*LANE_W +: LANE_W]),
        .imm    (imm_r),
        .result (alu_y1_s)
    );
`endif

    // Next-state, lane counter and result assembly.
    always_comb begin
        state_nxt_s  = state_r;
        lane_nxt_s   = lane_r;
        result_nxt_s = result_r;
        accept_s     = 1'b0;
        case (state_r)
            VSEQ_IDLE: begin
                if (I_Valid && is_vec_op(I_Opcode)) begin
                    accept_s     = 1'b1;
                    lane_nxt_s   = {LANE_ID_W{1'b0}};
                    result_nxt_s = is_comp_op(I_Opcode) ? I_VecSrc1Value : {VEC_W{1'b0}};
                    state_nxt_s  = VSEQ_RUN;
                end else begin
                    state_nxt_s  = VSEQ_IDLE;
                end
            end
            VSEQ_RUN: begin
                if (comp_s) begin
                    result_nxt_s[idx_r*LANE_W +: LANE_W] = alu_y0_s;
                    lane_nxt_s  = {LANE_ID_W{1'b0}};
                    state_nxt_s = VSEQ_DONE;
                end else begin
                    result_nxt_s[lane_r*LANE_W +: LANE_W] = alu_y0_s;
`ifdef VEC_LANE_PAIR_EN
                    result_nxt_s[lane_hi_s*LANE_W +: LANE_W] = alu_y1_s;
`endif
                    if (lane_r == LAST_LANE) begin
                        lane_nxt_s  = {LANE_ID_W{1'b0}};
                        state_nxt_s = VSEQ_DONE;
                    end else begin
                        lane_nxt_s  = lane_r + STEP;
                        state_nxt_s = VSEQ_RUN;
                    end
                end
            end
            VSEQ_DONE: begin
                if (!I_GPUStallSignal) begin
                    state_nxt_s = VSEQ_IDLE;
                end else begin
                    state_nxt_s = VSEQ_DONE;
                end
            end
            default: begin
                lane_nxt_s  = {LANE_ID_W{1'b0}};
                state_nxt_s = VSEQ_IDLE;
            end
        endcase
    end

    // Control state plus handshake outputs, registered from the next state.
    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            state_r  <= VSEQ_IDLE;
            lane_r   <= {LANE_ID_W{1'b0}};
            result_r <= {VEC_W{1'b0}};
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            lane_r   <= lane_nxt_s;
            result_r <= result_nxt_s;
            ready_r  <= (state_nxt_s == VSEQ_IDLE);
            valid_r  <= (state_nxt_s == VSEQ_DONE);
            busy_r   <= (state_nxt_s != VSEQ_IDLE);
        end
    end

    // Operand capture; held for the whole op so DE may change its outputs freely.
    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            s1_r   <= {VEC_W{1'b0}};
            s2_r   <= {VEC_W{1'b0}};
            imm_r  <= {LANE_W{1'b0}};
            idx_r  <= {LANE_ID_W{1'b0}};
            op_r   <= {OPCODE_WIDTH{1'b0}};
            dest_r <= {VREG_ID_WIDTH{1'b0}};
        end else if (accept_s) begin
            s1_r   <= I_VecSrc1Value;
            s2_r   <= I_VecSrc2Value;
            imm_r  <= I_Imm;
            idx_r  <= I_Idx;
            op_r   <= I_Opcode;
            dest_r <= I_DestVRegIdx;
        end
    end

    assign O_Ready        = ready_r;
    assign O_Valid        = valid_r;
    assign O_VRegWEn      = valid_r;
    assign O_Busy         = busy_r;
    assign O_DestVRegIdx  = dest_r;
    assign O_VecDestValue = result_r;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Directed self-checking bench for vec_lane_sequencer (default LANES=4, LANE_W=16).
// "Observed at edge N" means the value sampled just after negedge N-1 settles.
module tb_vec_lane_sequencer;
    import vec_lane_sequencer_pkg::*;

`ifdef VEC_LANE_PAIR_EN
    localparam int RUN_CYC = 2;
`else
    localparam int RUN_CYC = 4;
`endif

    logic        I_CLOCK, I_RESET, I_Valid, I_GPUStallSignal;
    logic [7:0]  I_Opcode;
    logic [5:0]  I_DestVRegIdx;
    logic [63:0] I_VecSrc1Value, I_VecSrc2Value;
    logic [15:0] I_Imm;
    logic [1:0]  I_Idx;
    logic        O_Ready, O_Valid, O_VRegWEn, O_Busy;
    logic [5:0]  O_DestVRegIdx;
    logic [63:0] O_VecDestValue;

    int vec_cnt = 0;
    int err_cnt = 0;

    vec_lane_sequencer #(.LANES(4), .LANE_W(16)) dut (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_Valid(I_Valid), .I_Opcode(I_Opcode),
        .I_DestVRegIdx(I_DestVRegIdx), .I_VecSrc1Value(I_VecSrc1Value),
        .I_VecSrc2Value(I_VecSrc2Value), .I_Imm(I_Imm), .I_Idx(I_Idx),
        .I_GPUStallSignal(I_GPUStallSignal), .O_Ready(O_Ready), .O_Valid(O_Valid),
        .O_DestVRegIdx(O_DestVRegIdx), .O_VecDestValue(O_VecDestValue),
        .O_VRegWEn(O_VRegWEn), .O_Busy(O_Busy)
    );

    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    task automatic tick();
        @(negedge I_CLOCK);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [5:0] dest, input logic [63:0] s1,
                         input logic [63:0] s2, input logic [15:0] imm, input logic [1:0] idx);
        I_Valid = 1'b1; I_Opcode = op; I_DestVRegIdx = dest;
        I_VecSrc1Value = s1; I_VecSrc2Value = s2; I_Imm = imm; I_Idx = idx;
    endtask

    task automatic test_reset();
        vec_cnt++;
        if ({O_Ready, O_Valid, O_VRegWEn, O_Busy} !== 4'b1000) begin
            err_cnt++; $display("FAIL reset_flags: got %b expected 1000", {O_Ready, O_Valid, O_VRegWEn, O_Busy});
        end
        vec_cnt++;
        if ({O_DestVRegIdx, O_VecDestValue} !== 70'd0) begin
            err_cnt++; $display("FAIL reset_data: got %h/%h expected 0/0", O_DestVRegIdx, O_VecDestValue);
        end
        I_RESET = 1'b0;
        tick();
        vec_cnt++;
        if ({O_Ready, O_Valid, O_Busy} !== 3'b100) begin
            err_cnt++; $display("FAIL reset_release: got %b expected 100", {O_Ready, O_Valid, O_Busy});
        end
    endtask

    task automatic test_vadd();
        issue(OP_VADD, 6'd3, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd1, 16'd1, 16'd1, 16'hFFFF}, 16'd0, 2'd0);
        tick();
        I_Valid = 1'b0;
        vec_cnt++;
        if ({O_Ready, O_Valid, O_Busy} !== 3'b001) begin
            err_cnt++; $display("FAIL vadd_accept: got %b expected 001", {O_Ready, O_Valid, O_Busy});
        end
        for (int k = 1; k < RUN_CYC; k++) begin
            tick();
            vec_cnt++;
            if (O_Valid !== 1'b0) begin
                err_cnt++; $display("FAIL vadd_early_valid: after edge %0d got %b expected 0", k, O_Valid);
            end
        end
        tick();
        vec_cnt++;
        if ({O_Valid, O_VRegWEn, O_Ready, O_Busy} !== 4'b1101) begin
            err_cnt++; $display("FAIL vadd_valid: got %b expected 1101", {O_Valid, O_VRegWEn, O_Ready, O_Busy});
        end
        vec_cnt++;
        if (O_VecDestValue !== 64'h0005_0004_0003_0000) begin
            err_cnt++; $display("FAIL vadd_result: got %h expected 0005000400030000", O_VecDestValue);
        end
        vec_cnt++;
        if (O_DestVRegIdx !== 6'd3) begin
            err_cnt++; $display("FAIL vadd_dest: got %0d expected 3", O_DestVRegIdx);
        end
        tick();
        vec_cnt++;
        if ({O_Ready, O_Valid, O_Busy} !== 3'b100) begin
            err_cnt++; $display("FAIL vadd_retire: got %b expected 100", {O_Ready, O_Valid, O_Busy});
        end
    endtask

    task automatic test_stall();
        I_GPUStallSignal = 1'b1;
        issue(OP_VMOVI, 6'd7, 64'h1234_5678_9ABC_DEF0, 64'h0, 16'h00A5, 2'd0);
        tick();
        I_Valid = 1'b0;
        repeat (RUN_CYC) tick();
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if (O_Valid !== 1'b1 || O_VecDestValue !== 64'h00A5_00A5_00A5_00A5) begin
                err_cnt++; $display("FAIL stall_hold: cycle %0d got %b/%h expected 1/00a500a500a500a5", i, O_Valid, O_VecDestValue);
            end
            if (i < 3) tick();
        end
        I_GPUStallSignal = 1'b0;
        tick();
        vec_cnt++;
        if ({O_Ready, O_Valid} !== 2'b10) begin
            err_cnt++; $display("FAIL stall_release: got %b expected 10", {O_Ready, O_Valid});
        end
    endtask

    task automatic test_comp();
        logic [7:0]  op_t  [3];
        logic [1:0]  idx_t [3];
        logic [63:0] s1_t  [3];
        logic [63:0] s2_t  [3];
        logic [15:0] imm_t [3];
        logic [63:0] exp_t [3];
        op_t[0] = OP_VCOMPMOVI; idx_t[0] = 2'd2; s1_t[0] = 64'h0009_0009_0009_0009;
        s2_t[0] = 64'hBEEF_BEEF_BEEF_BEEF; imm_t[0] = 16'd7; exp_t[0] = 64'h0009_0007_0009_0009;
        op_t[1] = OP_VCOMPMOV; idx_t[1] = 2'd0; s1_t[1] = 64'h0001_0002_0003_0004;
        s2_t[1] = 64'hAAAA_BBBB_CCCC_1234; imm_t[1] = 16'h5555; exp_t[1] = 64'h0001_0002_0003_1234;
        op_t[2] = OP_VCOMPMOVI; idx_t[2] = 2'd3; s1_t[2] = 64'h0;
        s2_t[2] = 64'h1111_1111_1111_1111; imm_t[2] = 16'hFFFF; exp_t[2] = 64'hFFFF_0000_0000_0000;
        for (int t = 0; t < 3; t++) begin
            issue(op_t[t], 6'd2, s1_t[t], s2_t[t], imm_t[t], idx_t[t]);
            tick();
            I_Valid = 1'b0;
            vec_cnt++;
            if ({O_Valid, O_Busy} !== 2'b01) begin
                err_cnt++; $display("FAIL comp_run: case %0d got %b expected 01", t, {O_Valid, O_Busy});
            end
            tick();
            vec_cnt++;
            if (O_Valid !== 1'b1 || O_VecDestValue !== exp_t[t]) begin
                err_cnt++; $display("FAIL comp_result: case %0d got %b/%h expected 1/%h", t, O_Valid, O_VecDestValue, exp_t[t]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        issue(OP_VADD, 6'd5, {16'd10, 16'd20, 16'd30, 16'd40}, {16'd1, 16'd2, 16'd3, 16'd4}, 16'd0, 2'd0);
        tick();
        issue(OP_VADD, 6'd9, 64'h8000_FFFF_0100_0001, 64'h8000_0002_0F00_0001, 16'd0, 2'd0);
        for (int k = 1; k <= RUN_CYC; k++) begin
            tick();
            if (k < RUN_CYC) begin
                vec_cnt++;
                if (O_Ready !== 1'b0) begin
                    err_cnt++; $display("FAIL b2b_ready_busy: after edge %0d got %b expected 0", k, O_Ready);
                end
            end
        end
        vec_cnt++;
        if (O_Valid !== 1'b1 || O_VecDestValue !== 64'h000B_0016_0021_002C || O_DestVRegIdx !== 6'd5) begin
            err_cnt++; $display("FAIL b2b_first: got %b/%h/%0d expected 1/000b00160021002c/5", O_Valid, O_VecDestValue, O_DestVRegIdx);
        end
        tick();
        vec_cnt++;
        if ({O_Ready, O_Valid} !== 2'b10) begin
            err_cnt++; $display("FAIL b2b_gap: got %b expected 10", {O_Ready, O_Valid});
        end
        tick();
        I_Valid = 1'b0;
        vec_cnt++;
        if ({O_Ready, O_Busy} !== 2'b01) begin
            err_cnt++; $display("FAIL b2b_second_accept: got %b expected 01", {O_Ready, O_Busy});
        end
        repeat (RUN_CYC) tick();
        vec_cnt++;
        if (O_Valid !== 1'b1 || O_VecDestValue !== 64'h0000_0001_1000_0002 || O_DestVRegIdx !== 6'd9) begin
            err_cnt++; $display("FAIL b2b_second: got %b/%h/%0d expected 1/0000000110000002/9", O_Valid, O_VecDestValue, O_DestVRegIdx);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        issue(OP_VMOV, 6'd4, 64'h1111_2222_3333_4444, 64'h0, 16'd0, 2'd0);
        tick();
        I_Valid = 1'b0;
        repeat (RUN_CYC / 2) tick();
        #1 I_RESET = 1'b1;
        #1;
        vec_cnt++;
        if ({O_Ready, O_Valid, O_VRegWEn, O_Busy} !== 4'b1000 || O_VecDestValue !== 64'h0 || O_DestVRegIdx !== 6'd0) begin
            err_cnt++; $display("FAIL midrun_reset: got %b/%h/%0d expected 1000/0/0", {O_Ready, O_Valid, O_VRegWEn, O_Busy}, O_VecDestValue, O_DestVRegIdx);
        end
        I_RESET = 1'b0;
        tick();
        vec_cnt++;
        if ({O_Ready, O_Valid, O_Busy} !== 3'b100) begin
            err_cnt++; $display("FAIL midrun_idle: got %b expected 100", {O_Ready, O_Valid, O_Busy});
        end
        issue(OP_VMOV, 6'd11, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF, 16'd0, 2'd0);
        tick();
        I_Valid = 1'b0;
        repeat (RUN_CYC) tick();
        vec_cnt++;
        if (O_Valid !== 1'b1 || O_VecDestValue !== 64'hDEAD_BEEF_0123_4567 || O_DestVRegIdx !== 6'd11) begin
            err_cnt++; $display("FAIL midrun_rerun: got %b/%h/%0d expected 1/deadbeef01234567/11", O_Valid, O_VecDestValue, O_DestVRegIdx);
        end
        tick();
    endtask

    task automatic test_non_vector();
        issue(OP_ADD_D, 6'd1, 64'h1, 64'h2, 16'd3, 2'd1);
        for (int k = 0; k < RUN_CYC + 2; k++) begin
            tick();
            vec_cnt++;
            if ({O_Ready, O_Valid, O_Busy} !== 3'b100) begin
                err_cnt++; $display("FAIL nonvec_ignored: cycle %0d got %b expected 100", k, {O_Ready, O_Valid, O_Busy});
            end
        end
        I_Valid = 1'b0;
    endtask

    initial begin
        I_RESET = 1'b1; I_Valid = 1'b0; I_Opcode = 8'd0; I_DestVRegIdx = 6'd0;
        I_VecSrc1Value = 64'd0; I_VecSrc2Value = 64'd0; I_Imm = 16'd0; I_Idx = 2'd0;
        I_GPUStallSignal = 1'b0;
        #12;
        test_reset();
        test_vadd();
        test_stall();
        test_comp();
        test_back_to_back();
        test_reset_mid_run();
        test_non_vector();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
